// File: rtl/hall_sensor_emulator_pkg.sv
// Shared constants for the Hall sensor emulator: register map, Hall codes and
// the gate patterns that are never treated as commutation errors.
package hall_sensor_emulator_pkg;

    localparam logic [3:0] ADDR_CTRL    = 4'd0;
    localparam logic [3:0] ADDR_STATUS  = 4'd1;
    localparam logic [3:0] ADDR_PER0    = 4'd2;
    localparam logic [3:0] ADDR_PER1    = 4'd3;
    localparam logic [3:0] ADDR_PER2    = 4'd4;
    localparam logic [3:0] ADDR_PER3    = 4'd5;
    localparam logic [3:0] ADDR_STEP_LO = 4'd6;
    localparam logic [3:0] ADDR_STEP_HI = 4'd7;
    localparam logic [3:0] ADDR_MM_CNT  = 4'd8;
    localparam logic [3:0] ADDR_FORCE   = 4'd9;
    localparam logic [3:0] ADDR_GATE    = 4'd10;

    // Hall codes are {Ha,Hb,Hc}
    localparam logic [2:0] H_100 = 3'b100;
    localparam logic [2:0] H_110 = 3'b110;
    localparam logic [2:0] H_010 = 3'b010;
    localparam logic [2:0] H_011 = 3'b011;
    localparam logic [2:0] H_001 = 3'b001;
    localparam logic [2:0] H_101 = 3'b101;

    // Gate patterns are {Lau,Lbu,Lcu,Lad,Lbd,Lcd}
    localparam logic [5:0] GATES_OFF   = 6'b000000;
    localparam logic [5:0] GATES_BRAKE = 6'b000111;

    typedef struct packed {
        logic dir;
        logic enable;
    } ctrl_t;

endpackage

// File: rtl/hall_sensor_emulator_if.sv
// 8-bit Avalon-MM control port of the Hall sensor emulator.
interface hall_sensor_emulator_if;
    logic [7:0] avs_ctrl_writedata;
    logic [7:0] avs_ctrl_readdata;
    logic [3:0] avs_ctrl_address;
    logic       avs_ctrl_write;
    logic       avs_ctrl_read;

    modport master (
        output avs_ctrl_writedata, avs_ctrl_address, avs_ctrl_write, avs_ctrl_read,
        input  avs_ctrl_readdata
    );
    modport slave (
        input  avs_ctrl_writedata, avs_ctrl_address, avs_ctrl_write, avs_ctrl_read,
        output avs_ctrl_readdata
    );
endinterface

// File: rtl/hall_sensor_emulator_step_seq.sv
// Combinational Hall sequencer: next Hall code for the given direction and the
// gate pattern the motor driver should present in the current Hall state.
module hall_step_seq
    import hall_sensor_emulator_pkg::*;
#(
    parameter logic [2:0] INIT_HALL = 3'b100
) (
    input  logic [2:0] hall_i,
    input  logic       dir_i,
    output logic [2:0] next_hall_o,
    output logic [5:0] exp_gates_o
);

    // Invalid codes 000/111 fall through to the defaults
    always_comb begin
        next_hall_o = INIT_HALL;
        exp_gates_o = GATES_OFF;
        case (hall_i)
            H_100: begin
                next_hall_o = dir_i ? H_110 : H_101;
                exp_gates_o = dir_i ? 6'b100001 : 6'b001100;
            end
            H_110: begin
                next_hall_o = dir_i ? H_010 : H_100;
                exp_gates_o = dir_i ? 6'b010001 : 6'b001010;
            end
            H_010: begin
                next_hall_o = dir_i ? H_011 : H_110;
                exp_gates_o = dir_i ? 6'b010100 : 6'b100010;
            end
            H_011: begin
                next_hall_o = dir_i ? H_001 : H_010;
                exp_gates_o = dir_i ? 6'b001100 : 6'b100001;
            end
            H_001: begin
                next_hall_o = dir_i ? H_101 : H_011;
                exp_gates_o = dir_i ? 6'b001010 : 6'b010001;
            end
            H_101: begin
                next_hall_o = dir_i ? H_100 : H_001;
                exp_gates_o = dir_i ? 6'b100010 : 6'b010100;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hall_sensor_emulator.sv
// Hall sensor emulator: steps Ha/Hb/Hc at a programmable rate and checks the
// motor driver's gate outputs for shoot-through and commutation mismatches.
module hall_sensor_emulator
    import hall_sensor_emulator_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter logic [2:0]  INIT_HALL    = 3'b100
) (
    input  logic                   csi_MCLK_clk,
    input  logic                   rsi_MRST_reset_n,
    hall_sensor_emulator_if.slave  avs_ctrl,
    input  logic                   Lau,
    input  logic                   Lbu,
    input  logic                   Lcu,
    input  logic                   Lad,
    input  logic                   Lbd,
    input  logic                   Lcd,
    output logic                   Ha,
    output logic                   Hb,
    output logic                   Hc,
    output logic                   fault_irq
);

    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
    localparam logic [GW-1:0] GUARD_ONE  = GW'(1);

    ctrl_t         ctrl_q, ctrl_d;
    logic [31:0]   shadow_q, shadow_d, period_q, period_d, cnt_q, cnt_d;
    logic [2:0]    hall_q, hall_d, force_q, force_d;
    logic [15:0]   step_cnt_q, step_cnt_d;
    logic [7:0]    mm_cnt_q, mm_cnt_d, rdata_q, rdata_d;
    logic          fault_q, fault_d, mism_q, mism_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [5:0]    gate_s1_q, gate_s2_q;

    logic [2:0] next_hall;
    logic [5:0] exp_gates;
    logic       wr, rd, step, shoot, check, mm_evt, clr;
    logic [3:0] addr;
    logic [7:0] wdata;

    hall_step_seq #(.INIT_HALL(INIT_HALL)) u_seq (
        .hall_i      (hall_q),
        .dir_i       (ctrl_q.dir),
        .next_hall_o (next_hall),
        .exp_gates_o (exp_gates)
    );

    assign wr     = avs_ctrl.avs_ctrl_write;
    assign rd     = avs_ctrl.avs_ctrl_read & ~wr;
    assign addr   = avs_ctrl.avs_ctrl_address;
    assign wdata  = avs_ctrl.avs_ctrl_writedata;

    assign step   = ctrl_q.enable && (period_q != 32'd0) && (cnt_q == period_q - 32'd1);
    assign shoot  = |(gate_s2_q[5:3] & gate_s2_q[2:0]);
    // The guard reaching one means GUARD_CYCLES clocks have passed since the step
    assign check  = ctrl_q.enable && (guard_q == GUARD_ONE);
    assign mm_evt = check && (gate_s2_q != GATES_OFF) && (gate_s2_q != GATES_BRAKE)
                    && (gate_s2_q != exp_gates);
    assign clr    = wr && (addr == ADDR_CTRL) && wdata[2];

    always_comb begin
        ctrl_d     = ctrl_q;
        shadow_d   = shadow_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        hall_d     = hall_q;
        force_d    = force_q;
        step_cnt_d = step_cnt_q;
        guard_d    = guard_q;

        if (wr) begin
            case (addr)
                ADDR_CTRL:  begin
                    ctrl_d.enable = wdata[0];
                    ctrl_d.dir    = wdata[1];
                end
                ADDR_PER0:  shadow_d[7:0]   = wdata;
                ADDR_PER1:  shadow_d[15:8]  = wdata;
                ADDR_PER2:  shadow_d[23:16] = wdata;
                ADDR_PER3:  shadow_d[31:24] = wdata;
                ADDR_FORCE: if (!ctrl_q.enable) force_d = wdata[2:0];
                default: ;
            endcase
        end

        if (!ctrl_q.enable) begin
            period_d = shadow_q;
            cnt_d    = 32'd0;
            guard_d  = '0;
            if (wr && addr == ADDR_FORCE) hall_d = wdata[2:0];
        end else if (step) begin
            cnt_d      = 32'd0;
            hall_d     = next_hall;
            step_cnt_d = step_cnt_q + 16'd1;
            period_d   = shadow_q;
            guard_d    = GUARD_LOAD;
        end else begin
            if (period_q != 32'd0) cnt_d = cnt_q + 32'd1;
            if (guard_q != '0) guard_d = guard_q - GUARD_ONE;
        end
    end

    // Set events are applied after the clear so they win on a collision
    always_comb begin
        fault_d  = fault_q;
        mism_d   = mism_q;
        mm_cnt_d = mm_cnt_q;
        if (clr) begin
            fault_d  = 1'b0;
            mism_d   = 1'b0;
            mm_cnt_d = 8'd0;
        end
        if (shoot) fault_d = 1'b1;
        if (mm_evt) begin
            mism_d = 1'b1;
            if (mm_cnt_d != 8'hFF) mm_cnt_d = mm_cnt_d + 8'd1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (addr)
                ADDR_CTRL:    rdata_d = {6'd0, ctrl_q.dir, ctrl_q.enable};
                ADDR_STATUS:  rdata_d = {2'd0, hall_q, mism_q, fault_q, ctrl_q.enable};
                ADDR_PER0:    rdata_d = shadow_q[7:0];
                ADDR_PER1:    rdata_d = shadow_q[15:8];
                ADDR_PER2:    rdata_d = shadow_q[23:16];
                ADDR_PER3:    rdata_d = shadow_q[31:24];
                ADDR_STEP_LO: rdata_d = step_cnt_q[7:0];
                ADDR_STEP_HI: rdata_d = step_cnt_q[15:8];
                ADDR_MM_CNT:  rdata_d = mm_cnt_q;
                ADDR_FORCE:   rdata_d = {5'd0, force_q};
                ADDR_GATE:    rdata_d = {2'd0, gate_s2_q};
                default:      rdata_d = 8'd0;
            endcase
        end
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            ctrl_q     <= '0;
            shadow_q   <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            hall_q     <= INIT_HALL;
            force_q    <= '0;
            step_cnt_q <= '0;
            mm_cnt_q   <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
            mism_q     <= 1'b0;
            guard_q    <= '0;
            gate_s1_q  <= '0;
            gate_s2_q  <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            shadow_q   <= shadow_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            hall_q     <= hall_d;
            force_q    <= force_d;
            step_cnt_q <= step_cnt_d;
            mm_cnt_q   <= mm_cnt_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
            mism_q     <= mism_d;
            guard_q    <= guard_d;
            gate_s1_q  <= {Lau, Lbu, Lcu, Lad, Lbd, Lcd};
            gate_s2_q  <= gate_s1_q;
        end
    end

    assign {Ha, Hb, Hc} = hall_q;
    assign fault_irq    = fault_q | mism_q;
    assign avs_ctrl.avs_ctrl_readdata = rdata_q;

endmodule
